// File: rtl/tcm_dp_ram_ctrl_if.sv
// Bus bundle for the dual-port TCM RAM.
// Port 0 serves fetch, port 1 serves load/store/DMA; collision status rides along.
interface tcm_dp_ram_ctrl_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
);
    localparam int NUM_WMASKS = DATA_WIDTH / 8;

    logic                  req0_i;
    logic                  we0_i;
    logic [NUM_WMASKS-1:0] wmask0_i;
    logic [ADDR_WIDTH-1:0] addr0_i;
    logic [DATA_WIDTH-1:0] wdata0_i;
    logic [DATA_WIDTH-1:0] rdata0_o;
    logic                  rvalid0_o;

    logic                  req1_i;
    logic                  we1_i;
    logic [NUM_WMASKS-1:0] wmask1_i;
    logic [ADDR_WIDTH-1:0] addr1_i;
    logic [DATA_WIDTH-1:0] wdata1_i;
    logic [DATA_WIDTH-1:0] rdata1_o;
    logic                  rvalid1_o;

    logic                  collision_o;
    logic [CNT_WIDTH-1:0]  collision_cnt_o;

    modport master (
        output req0_i, we0_i, wmask0_i, addr0_i, wdata0_i,
        input  rdata0_o, rvalid0_o,
        output req1_i, we1_i, wmask1_i, addr1_i, wdata1_i,
        input  rdata1_o, rvalid1_o,
        input  collision_o, collision_cnt_o
    );

    modport slave (
        input  req0_i, we0_i, wmask0_i, addr0_i, wdata0_i,
        output rdata0_o, rvalid0_o,
        input  req1_i, we1_i, wmask1_i, addr1_i, wdata1_i,
        output rdata1_o, rvalid1_o,
        output collision_o, collision_cnt_o
    );
endinterface

// File: rtl/tcm_dp_ram_ctrl.sv
// True dual-port TCM RAM: byte-lane writes, port 0 write priority,
// selectable read-during-write, optional output stage, collision counter.
module tcm_dp_ram_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_WMASKS = DATA_WIDTH / 8,
    parameter int RDW_MODE   = 0,
    parameter int OUT_REG    = 0,
    parameter int CNT_WIDTH  = 16
) (
    input logic              clk_i,
    input logic              rst_i,
    tcm_dp_ram_ctrl_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic wr0;
    logic wr1;
    logic rd0;
    logic rd1;
    logic same_addr;
    logic coll;

    assign wr0 = ~rst_i & bus.req0_i & bus.we0_i;
    assign wr1 = ~rst_i & bus.req1_i & bus.we1_i;
    assign rd0 = ~rst_i & bus.req0_i & ~bus.we0_i;
    assign rd1 = ~rst_i & bus.req1_i & ~bus.we1_i;
    assign same_addr = (bus.addr0_i == bus.addr1_i);
    assign coll = ~rst_i & bus.req0_i & bus.req1_i & same_addr
                & (bus.we0_i | bus.we1_i);

    // Port 1 lanes land first so a shared lane ends up with port 0 data.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NUM_WMASKS; b++) begin
            if (wr1 && bus.wmask1_i[b])
                mem[bus.addr1_i][b*8 +: 8] <= bus.wdata1_i[b*8 +: 8];
            if (wr0 && bus.wmask0_i[b])
                mem[bus.addr0_i][b*8 +: 8] <= bus.wdata0_i[b*8 +: 8];
        end
    end

    logic [DATA_WIDTH-1:0] old0;
    logic [DATA_WIDTH-1:0] old1;
    logic [DATA_WIDTH-1:0] byp0;
    logic [DATA_WIDTH-1:0] byp1;
    logic [DATA_WIDTH-1:0] rd_next0;
    logic [DATA_WIDTH-1:0] rd_next1;

    assign old0 = mem[bus.addr0_i];
    assign old1 = mem[bus.addr1_i];

    always_comb begin
        byp0 = old0;
        byp1 = old1;
        for (int b = 0; b < NUM_WMASKS; b++) begin
            if (bus.wmask1_i[b])
                byp0[b*8 +: 8] = bus.wdata1_i[b*8 +: 8];
            if (bus.wmask0_i[b])
                byp1[b*8 +: 8] = bus.wdata0_i[b*8 +: 8];
        end
    end

    assign rd_next0 = (RDW_MODE != 0 && wr1 && same_addr) ? byp0 : old0;
    assign rd_next1 = (RDW_MODE != 0 && wr0 && same_addr) ? byp1 : old1;

    logic                  v0_q;
    logic                  v1_q;
    logic [DATA_WIDTH-1:0] d0_q;
    logic [DATA_WIDTH-1:0] d1_q;
    logic                  coll_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v0_q   <= 1'b0;
            v1_q   <= 1'b0;
            d0_q   <= '0;
            d1_q   <= '0;
            coll_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            v0_q   <= rd0;
            v1_q   <= rd1;
            coll_q <= coll;
            if (rd0)
                d0_q <= rd_next0;
            if (rd1)
                d1_q <= rd_next1;
            if (coll && !(&cnt_q))
                cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign bus.collision_o     = coll_q;
    assign bus.collision_cnt_o = cnt_q;

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic                  v0_r;
            logic                  v1_r;
            logic [DATA_WIDTH-1:0] d0_r;
            logic [DATA_WIDTH-1:0] d1_r;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    v0_r <= 1'b0;
                    v1_r <= 1'b0;
                    d0_r <= '0;
                    d1_r <= '0;
                end else begin
                    v0_r <= v0_q;
                    v1_r <= v1_q;
                    if (v0_q)
                        d0_r <= d0_q;
                    if (v1_q)
                        d1_r <= d1_q;
                end
            end

            assign bus.rdata0_o  = d0_r;
            assign bus.rdata1_o  = d1_r;
            assign bus.rvalid0_o = v0_r;
            assign bus.rvalid1_o = v1_r;
        end else begin : g_noreg
            assign bus.rdata0_o  = d0_q;
            assign bus.rdata1_o  = d1_q;
            assign bus.rvalid0_o = v0_q;
            assign bus.rvalid1_o = v1_q;
        end
    endgenerate
endmodule
